flag_unit: RTL
==============

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The module SHALL have exactly one clock and one reset, with the reset asynchronous and active-high, on the following ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
REQ-002 The module SHALL have the following ports, in addition to clk and reset:
- ALUFlags  input  4  new flags from the execute-stage ALU, ordered {N,Z,C,V}.
- FlagW  input  2  write mask: [1] selects N,Z; [0] selects C,V.
- CondEx  input  1  the condition-check result for the execute-stage instruction.
- Valid  input  1  the execute-stage instruction is real (not a bubble).
- Stall  input  1  holds the execute stage; no capture takes place.
- Flush  input  1  kills the execute-stage instruction; no capture takes place.
- Save  input  1  snapshots the flags into the shadow register.
- Restore  input  1  reloads the architectural flags from the shadow register.
- Flags  output  4  {N,Z,C,V} presented to the condition-check logic.
- Pending  output  1  a captured flag write is awaiting commit.
- FlagsSaved  output  4  shadow register contents.

Function
REQ-003 Capture enable SHALL be CapEn = Valid & CondEx & (FlagW != 0) & ~Stall & ~Flush & ~Restore.
REQ-004 On a clock edge with CapEn=1, the unit SHALL load PendFlags<=ALUFlags, PendMask<=FlagW and PendV<=1.
REQ-005 On a clock edge with CapEn=0, the unit SHALL set PendV<=0, and PendFlags/PendMask SHALL hold their values.
REQ-006 On a clock edge with PendV=1 and Restore=0, the architectural register ArchFlags SHALL update only the bit pairs selected by PendMask, and all other bits SHALL hold.
REQ-007 A pending commit SHALL NOT be affected by Stall or Flush, because it belongs to an older, already-retired instruction.
REQ-008 Write latency SHALL be: an instruction that captures in cycle N appears in ArchFlags from cycle N+2.
REQ-009 Back-to-back captures SHALL be lossless: a commit of the pending write and a new capture on the same edge both take effect.
REQ-010 The effective flags SHALL be EffFlags = ArchFlags with the PendMask-selected pairs replaced by PendFlags when PendV=1, and EffFlags = ArchFlags otherwise.
REQ-011 On a clock edge with Save=1 and Restore=0, the unit SHALL load FlagsSaved<=EffFlags.
REQ-012 On a clock edge with Restore=1, the unit SHALL load ArchFlags<=FlagsSaved, discard any pending write (PendV<=0, no commit), suppress capture, and ignore Save.
REQ-013 Pending SHALL equal PendV.
REQ-014 All state SHALL change only on the rising edge of clk or on assertion of reset.
REQ-015 Flags SHALL be driven as specified under Configuration.

Reset
REQ-016 While reset=1, the unit SHALL immediately force ArchFlags=0000, PendFlags=0000, PendMask=00, PendV=0 and FlagsSaved=0000; outputs SHALL therefore read Flags=0000, Pending=0, FlagsSaved=0000.
REQ-017 A reset asserted mid-operation SHALL discard any pending write and any same-cycle Save or Restore.
REQ-018 The first capture SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-019 With macro FLAG_BYPASS_EN defined, Flags SHALL equal EffFlags (combinational forwarding of the pending write), so a dependent instruction sees new flags one cycle after capture.
REQ-020 With FLAG_BYPASS_EN undefined, Flags SHALL equal ArchFlags, with no combinational path from the pending registers to Flags; the pipeline's hazard unit stalls one extra cycle using Pending.

Verification
REQ-021 Reset then idle: reset pulse -> Flags=0000, Pending=0, FlagsSaved=0000 throughout.
REQ-022 Masked write: ALUFlags=1111, FlagW=10, Valid=CondEx=1 in cycle N -> Pending=1 in cycle N+1, ArchFlags=1100 in cycle N+2; Flags=1100 in cycle N+1 only if FLAG_BYPASS_EN is defined, otherwise in cycle N+2.
REQ-023 Gating: the same stimulus with CondEx=0, or Stall=1, or Flush=1, or FlagW=00 -> Pending stays 0 and Flags stays 0000.
REQ-024 Back-to-back: cycle N ALUFlags=1000, FlagW=10; cycle N+1 ALUFlags=0011, FlagW=01 -> ArchFlags=1000 in cycle N+2 and 1011 in cycle N+3.
REQ-025 Save/Restore: with flags 0110, assert Save; write 1001 with FlagW=11; then Restore while a capture of 1111 is pending -> FlagsSaved=0110, Flags=0110 after Restore, Pending=0, and 1111 never appears.
REQ-026 Async reset while Pending=1 -> Pending drops and Flags=0000 immediately, before the next clk edge.

Source files
------------

// File: rtl/flag_unit.sv
// flag_unit -- condition-flag register for a pipelined core.
//
// Purpose:
//   Captures the execute-stage ALU flags into a one-entry pending stage,
//   commits them into the architectural flags one cycle later under a
//   per-pair write mask, and keeps a shadow copy that can be saved and
//   restored (for example around an exception entry/return).
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-high reset
//   ALUFlags   in   4  new flags from the execute-stage ALU, {N,Z,C,V}
//   FlagW      in   2  write mask: [1] selects N,Z; [0] selects C,V
//   CondEx     in   1  condition-check result of the execute instruction
//   Valid      in   1  execute-stage instruction is real (not a bubble)
//   Stall      in   1  execute stage held; no capture
//   Flush      in   1  execute instruction killed; no capture
//   Save       in   1  snapshot the effective flags into the shadow register
//   Restore    in   1  reload the architectural flags from the shadow register
//   Flags      out  4  {N,Z,C,V} presented to the condition-check logic
//   Pending    out  1  a captured flag write is awaiting commit
//   FlagsSaved out  4  shadow register contents
//
// Configuration:
//   FLAG_BYPASS_EN  when defined, Flags forwards the pending write
//                   combinationally (Flags = effective flags). When undefined,
//                   Flags is the architectural register only and the hazard
//                   unit is expected to stall on Pending.

module flag_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondEx,
  input  logic       Valid,
  input  logic       Stall,
  input  logic       Flush,
  input  logic       Save,
  input  logic       Restore,
  output logic [3:0] Flags,
  output logic       Pending,
  output logic [3:0] FlagsSaved
);

  // Replace the bit pairs of 'base' selected by 'mask' with those of 'upd'.
  // mask[1] covers {N,Z} (bits 3:2), mask[0] covers {C,V} (bits 1:0).
  function automatic logic [3:0] merge_flags(input logic [3:0] base,
                                             input logic [3:0] upd,
                                             input logic [1:0] mask);
    logic [3:0] res;
    res[3:2] = mask[1] ? upd[3:2] : base[3:2];
    res[1:0] = mask[0] ? upd[1:0] : base[1:0];
    return res;
  endfunction

  logic [3:0] arch_flags_r;
  logic [3:0] pend_flags_r;
  logic [1:0] pend_mask_r;
  logic       pend_v_r;
  logic [3:0] saved_r;

  logic       cap_en_s;
  logic [3:0] eff_flags_s;
  logic [3:0] arch_next_s;
  logic [3:0] pend_flags_next_s;
  logic [1:0] pend_mask_next_s;
  logic       pend_v_next_s;
  logic [3:0] saved_next_s;

  // Restore suppresses capture: the restored flags supersede anything in flight.
  assign cap_en_s = Valid & CondEx & (FlagW != 2'b00) & ~Stall & ~Flush & ~Restore;

  // Effective flags: architectural flags overlaid with the in-flight write.
  always_comb begin
    eff_flags_s = arch_flags_r;
    if (pend_v_r) begin
      eff_flags_s = merge_flags(arch_flags_r, pend_flags_r, pend_mask_r);
    end else begin
      eff_flags_s = arch_flags_r;
    end
  end

  // Next-state for the architectural, pending and shadow registers.
  always_comb begin
    arch_next_s       = arch_flags_r;
    pend_flags_next_s = pend_flags_r;
    pend_mask_next_s  = pend_mask_r;
    pend_v_next_s     = 1'b0;
    saved_next_s      = saved_r;

    // The pending write belongs to an already-retired instruction, so it
    // commits regardless of Stall/Flush; only Restore discards it.
    if (Restore) begin
      arch_next_s = saved_r;
    end else if (pend_v_r) begin
      arch_next_s = merge_flags(arch_flags_r, pend_flags_r, pend_mask_r);
    end else begin
      arch_next_s = arch_flags_r;
    end

    // A new capture may land on the same edge as the commit of the previous
    // one, which keeps back-to-back flag writers lossless.
    if (cap_en_s) begin
      pend_flags_next_s = ALUFlags;
      pend_mask_next_s  = FlagW;
      pend_v_next_s     = 1'b1;
    end else begin
      pend_flags_next_s = pend_flags_r;
      pend_mask_next_s  = pend_mask_r;
      pend_v_next_s     = 1'b0;
    end

    // Save snapshots the effective flags so an in-flight write is not lost.
    if (Restore) begin
      saved_next_s = saved_r;
    end else if (Save) begin
      saved_next_s = eff_flags_s;
    end else begin
      saved_next_s = saved_r;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arch_flags_r <= 4'b0000;
      pend_flags_r <= 4'b0000;
      pend_mask_r  <= 2'b00;
      pend_v_r     <= 1'b0;
      saved_r      <= 4'b0000;
    end else begin
      arch_flags_r <= arch_next_s;
      pend_flags_r <= pend_flags_next_s;
      pend_mask_r  <= pend_mask_next_s;
      pend_v_r     <= pend_v_next_s;
      saved_r      <= saved_next_s;
    end
  end

`ifdef FLAG_BYPASS_EN
  assign Flags = eff_flags_s;
`else
  assign Flags = arch_flags_r;
`endif

  assign Pending    = pend_v_r;
  assign FlagsSaved = saved_r;

endmodule
